// File: rtl/sn74123_mono.sv
// sn74123_mono: dual retriggerable monostable, fully synchronous to mclk.
// Pulse widths are counted in mclk cycles. Both channels share one
// implementation, built by a generate loop over the channel index.
// Optional feature macro: SN74123_RETRIGGER_EN
//   defined   -> an edge during a pulse reloads the counter (74123 style)
//   undefined -> edges during a pulse are ignored (74121 style)
module sn74123_mono #(
  parameter int CW     = 8,
  parameter int PULSE1 = 10,
  parameter int PULSE2 = 10
) (
  input  logic mclk,
  input  logic reset,
  input  logic a1_n,
  input  logic b1,
  input  logic clr1_n,
  output logic q1,
  output logic q1_n,
  input  logic a2_n,
  input  logic b2,
  input  logic clr2_n,
  output logic q2,
  output logic q2_n
);

`ifdef SN74123_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  // Channel-indexed views of the ports so one generate body serves both
  logic [1:0] a_n_w;
  logic [1:0] b_w;
  logic [1:0] clr_n_w;
  logic [1:0] q_w;

  assign a_n_w   = {a2_n, a1_n};
  assign b_w     = {b2, b1};
  assign clr_n_w = {clr2_n, clr1_n};

  assign q1   = q_w[0];
  assign q1_n = ~q_w[0];
  assign q2   = q_w[1];
  assign q2_n = ~q_w[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      localparam int PULSE = (gi == 0) ? PULSE1 : PULSE2;
      // n-1 always fits in CW bits because n <= 2**CW
      localparam logic [CW-1:0] LOAD = CW'(PULSE - 1);

      logic          trig;
      logic          trig_edge;
      logic          trig_prev_q, trig_prev_d;
      logic          q_q, q_d;
      logic [CW-1:0] cnt_q, cnt_d;

      // The three device triggers collapse into one combined level; only
      // its rising edge fires, so a level held through reset never fires.
      assign trig      = ~a_n_w[gi] & b_w[gi] & clr_n_w[gi];
      assign trig_edge = trig & ~trig_prev_q;

      // Next-state: clear, start, optional reload, end of pulse, count down
      always_comb begin
        trig_prev_d = trig;
        q_d         = q_q;
        cnt_d       = cnt_q;
        if (!clr_n_w[gi]) begin
          q_d   = 1'b0;
          cnt_d = '0;
        end else if (trig_edge && (!q_q || RETRIG)) begin
          // Start a pulse, or restart the count of a running one
          q_d   = 1'b1;
          cnt_d = LOAD;
        end else if (q_q && (cnt_q == '0)) begin
          // Reached when idle-edge is ignored too, so the pulse still ends
          q_d = 1'b0;
        end else if (q_q) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // State registers; trig_prev resets high so an active trigger must drop first
      always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
          trig_prev_q <= 1'b1;
          q_q         <= 1'b0;
          cnt_q       <= '0;
        end else begin
          trig_prev_q <= trig_prev_d;
          q_q         <= q_d;
          cnt_q       <= cnt_d;
        end
      end

      assign q_w[gi] = q_q;
    end
  endgenerate

endmodule

// File: tb/tb_sn74123_mono.sv
// tb_sn74123_mono: directed checks of sn74123_mono with PULSE1=10, PULSE2=3.
// Expected values follow SN74123_RETRIGGER_EN exactly as the design does.
module tb_sn74123_mono;

  logic mclk;
  logic reset;
  logic a1_n, b1, clr1_n;
  logic a2_n, b2, clr2_n;
  logic q1, q1_n, q2, q2_n;

  int checks;
  int passes;
  int qn_bad;

  sn74123_mono #(
    .CW(8),
    .PULSE1(10),
    .PULSE2(3)
  ) dut (
    .mclk(mclk),
    .reset(reset),
    .a1_n(a1_n),
    .b1(b1),
    .clr1_n(clr1_n),
    .q1(q1),
    .q1_n(q1_n),
    .a2_n(a2_n),
    .b2(b2),
    .clr2_n(clr2_n),
    .q2(q2),
    .q2_n(q2_n)
  );

`ifdef SN74123_RETRIGGER_EN
  localparam int EXP_RETRIG_W = 16;
  localparam int EXP_CH2_HIGH = 12;
  localparam logic EXP_CH2_P3 = 1'b1;
  localparam logic EXP_CH2_P11 = 1'b1;
`else
  localparam int EXP_RETRIG_W = 10;
  localparam int EXP_CH2_HIGH = 6;
  localparam logic EXP_CH2_P3 = 1'b0;
  localparam logic EXP_CH2_P11 = 1'b0;
`endif

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      passes++;
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock and settle just after the edge; track the q_n invariant
  task automatic step();
    @(posedge mclk);
    #1;
    if (q1_n !== ~q1 || q2_n !== ~q2) qn_bad++;
  endtask

  initial begin
    int h1, h2;
    checks = 0;
    passes = 0;
    qn_bad = 0;
    reset  = 1'b1;
    a1_n = 1'b1; b1 = 1'b1; clr1_n = 1'b1;
    a2_n = 1'b1; b2 = 1'b0; clr2_n = 1'b1;
    step();
    check("rst_q1", q1, 1'b0);
    check("rst_q1_n", q1_n, 1'b1);
    check("rst_q2", q2, 1'b0);
    reset = 1'b0;
    step();

    // Single trigger: 10-cycle pulse, rising on the first sampling edge
    a1_n = 1'b0;
    h1 = 0; h2 = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      h1 += int'(q1);
      h2 += int'(q2);
      if (i == 0) check("single_latency", q1, 1'b1);
      if (i == 9) check("single_last_high", q1, 1'b1);
      if (i == 10) check("single_fall", q1, 1'b0);
    end
    check("single_width", h1, 10);
    check("ch2_idle", h2, 0);
    a1_n = 1'b1;
    step();

    // Trigger held active through reset must not fire
    a1_n  = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    h1 = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      h1 += int'(q1);
    end
    check("held_trig_no_fire", h1, 0);
    a1_n = 1'b1;
    step();
    a1_n = 1'b0;
    h1 = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      h1 += int'(q1);
    end
    check("after_release_width", h1, 10);
    a1_n = 1'b1;
    step();

    // Second edge 6 cycles after the first
    a1_n = 1'b0;
    h1 = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      h1 += int'(q1);
      if (i == 4) a1_n = 1'b1;
      if (i == 5) a1_n = 1'b0;
    end
    check("retrig_width", h1, EXP_RETRIG_W);
    a1_n = 1'b1;
    step();

    // Clear mid-pulse, then clear-rise retriggers
    a1_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 3) begin
        check("clr_before", q1, 1'b1);
        clr1_n = 1'b0;
      end
      if (i == 4) check("clr_fall", q1, 1'b0);
      if (i == 5) clr1_n = 1'b1;
    end
    h1 = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      h1 += int'(q1);
      if (i == 0) check("clr_rise_latency", q1, 1'b1);
    end
    check("clr_rise_width", h1, 10);
    a1_n = 1'b1;
    step();

    // Channel 2: a2_n low, b2 rising every 3 cycles (edges at P0,P3,P6,P9)
    a2_n = 1'b0;
    b2   = 1'b0;
    step();
    h2 = 0;
    for (int i = 0; i < 15; i++) begin
      b2 = ((i % 3) == 0) && (i <= 9);
      step();
      h2 += int'(q2);
      if (i == 3) check("ch2_p3", q2, EXP_CH2_P3);
      if (i == 11) check("ch2_p11", q2, EXP_CH2_P11);
      if (i == 12) check("ch2_p12", q2, 1'b0);
    end
    check("ch2_high_cycles", h2, EXP_CH2_HIGH);
    check("ch2_ch1_quiet", q1, 1'b0);
    a2_n = 1'b1;
    b2   = 1'b0;
    step();

    // Asynchronous reset mid-pulse, observed between clock edges
    a1_n = 1'b0;
    step();
    step();
    step();
    check("async_pre", q1, 1'b1);
    a1_n  = 1'b1;
    reset = 1'b1;
    #2;
    check("async_q1", q1, 1'b0);
    check("async_q1_n", q1_n, 1'b1);
    step();
    reset = 1'b0;
    step();
    check("async_after", q1, 1'b0);

    check("qn_invariant", qn_bad, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
